div_mc_ctrl: RTL and testbench
==============================

# div_mc_ctrl

Multicycle sequencer for the single-cycle combinational divider in the pipelined core's execute stage. It sits directly upstream of the divider: it latches the divide operands, holds them stable at the divider inputs for a fixed number of cycles, and stalls the pipeline meanwhile. This lets the divider be constrained as a multicycle path instead of limiting the clock. It then captures the divider output into a result register and pulses completion to the writeback path.

## Interface
Parameters:
- DATA_WIDTH, 32, operand/result width
- DIV_CTRL, 3, width of divide control code (100 DIV, 101 DIVU, 110 REM, 111 REMU)
- SETTLE_CYCLES, 4, cycles operands are held before capture; legal range 1..15

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start_i  in  1  execute stage presents an instruction this cycle
- div_ctrl_i  in  DIV_CTRL  control code; bit 2 set = divide op
- op1_i  in  DATA_WIDTH  dividend
- op2_i  in  DATA_WIDTH  divisor
- flush_i  in  1  pipeline flush; abort any operation
- div_op1_o  out  DATA_WIDTH  latched dividend to divider
- div_op2_o  out  DATA_WIDTH  latched divisor to divider
- div_ctrl_o  out  DIV_CTRL  latched control to divider
- div_result_i  in  DATA_WIDTH  divider combinational result
- stall_o  out  1  freeze upstream pipeline registers
- done_o  out  1  one-cycle pulse, result_o valid
- result_o  out  DATA_WIDTH  captured result, held until next capture

## Operation
- States: IDLE, SETTLE, DONE. Counter cnt is 4 bits wide.
- Reset (async, rst_n=0): state IDLE, cnt 0, div_op1_o/div_op2_o/div_ctrl_o/result_o 0, done_o 0, stall_o 0.
- IDLE:
  - If start_i and div_ctrl_i[2] and not flush_i: latch op1_i, op2_i, div_ctrl_i; cnt ← SETTLE_CYCLES-1; go to SETTLE.
  - Start with div_ctrl_i[2]=0 is ignored.
- SETTLE:
  - If cnt==0: result_o ← div_result_i (or the fixup value, see Configuration); go to DONE.
  - Otherwise cnt ← cnt-1.
- DONE: done_o=1 for this one cycle; go to IDLE. start_i in DONE is ignored, because the divide instruction itself advances this cycle.
- flush_i in any state: go to IDLE on the next edge. No capture and no done_o. result_o keeps its old value. flush_i has priority over start and over capture.
- stall_o is combinational: (IDLE & start_i & div_ctrl_i[2] & ~flush_i) | SETTLE. It is low in DONE.
- Latched operands stay constant from the entering edge until the next accepted start. This is the multicycle-path guarantee.

## Timing
- Start accepted in cycle 0.
- SETTLE occupies cycles 1..SETTLE_CYCLES.
- Capture happens on the edge ending cycle SETTLE_CYCLES.
- done_o is high in cycle SETTLE_CYCLES+1.
- stall_o is high in cycles 0..SETTLE_CYCLES.
- Total latency is SETTLE_CYCLES+1 cycles, the same for every operand value, fixups included.
- Back-to-back divides: the next start can be accepted at the earliest one cycle after DONE. Throughput is 1 per SETTLE_CYCLES+2 cycles.
- If rst_n is asserted mid-operation, all outputs drop immediately to their reset values.

## Configuration
- Macro DIV_RISCV_FIXUP_EN.
- When defined, the RISC-V special cases are evaluated from the latched operands and override div_result_i at capture:
  - divisor 0: DIV/DIVU give all-ones; REM/REMU give op1.
  - signed overflow (op1 = most negative value, op2 = all-ones): DIV gives op1; REM gives 0.
- When undefined, result_o is always div_result_i. The divider's own divide-by-zero result (0) passes through.
- Timing is identical either way.

## Test plan
- Reset then DIVU 100/7, SETTLE_CYCLES=4: stall_o high for cycles 0-4, done_o pulse in cycle 5, result_o=14, latched operands constant throughout.
- REM signed -7 % 2: result_o=0xFFFFFFFF (-1). Then start in the DONE cycle: ignored, no new stall.
- DIV 5/0: with DIV_RISCV_FIXUP_EN, result_o=0xFFFFFFFF; without it, result_o=0. Same latency in both builds.
- DIV 0x80000000/0xFFFFFFFF with macro: result_o=0x80000000. REM with the same operands: result_o=0.
- flush_i in cycle 2 of a divide: IDLE next cycle, stall_o low, no done_o, result_o unchanged. flush_i together with start in IDLE: not accepted.
- rst_n pulled low asynchronously mid-SETTLE: stall_o, done_o and result_o are 0 immediately. After release, a start of ADD (div_ctrl_i=000) gives no stall and no done.

Source files
------------

// File: rtl/div_mc_ctrl.sv
// Multicycle sequencer for a combinational divider: holds latched operands for SETTLE_CYCLES, then captures the result.
// Optional RISC-V divide-by-zero / signed-overflow result fixup enabled by defining DIV_RISCV_FIXUP_EN.
module div_mc_ctrl #(
  parameter int DATA_WIDTH    = 32,
  parameter int DIV_CTRL      = 3,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [DIV_CTRL-1:0]   div_ctrl_i,
  input  logic [DATA_WIDTH-1:0] op1_i,
  input  logic [DATA_WIDTH-1:0] op2_i,
  input  logic                  flush_i,
  output logic [DATA_WIDTH-1:0] div_op1_o,
  output logic [DATA_WIDTH-1:0] div_op2_o,
  output logic [DIV_CTRL-1:0]   div_ctrl_o,
  input  logic [DATA_WIDTH-1:0] div_result_i,
  output logic                  stall_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic [1:0]            state_dbg_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DONE   = 2'd2
  } state_e;

  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);
  localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  state_e                state_q;
  logic [3:0]            cnt_q;
  logic [DATA_WIDTH-1:0] op1_q;
  logic [DATA_WIDTH-1:0] op2_q;
  logic [DIV_CTRL-1:0]   ctrl_q;
  logic [DATA_WIDTH-1:0] result_q;
  logic [DATA_WIDTH-1:0] result_d;
  logic                  done_q;
  logic                  accept;

  assign accept = (state_q == IDLE) & start_i & div_ctrl_i[2] & ~flush_i;

  // Value captured at the end of SETTLE; special cases come from the latched operands.
  always_comb begin
    result_d = div_result_i;
`ifdef DIV_RISCV_FIXUP_EN
    if (op2_q == '0) begin
      result_d = ctrl_q[1] ? op1_q : '1;
    end else if (!ctrl_q[0] && (op1_q == MOST_NEG) && (op2_q == '1)) begin
      result_d = ctrl_q[1] ? '0 : op1_q;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op1_q    <= '0;
      op2_q    <= '0;
      ctrl_q   <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (flush_i) begin
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (accept) begin
              op1_q   <= op1_i;
              op2_q   <= op2_i;
              ctrl_q  <= div_ctrl_i;
              cnt_q   <= CNT_INIT;
              state_q <= SETTLE;
            end
          end
          SETTLE: begin
            if (cnt_q == 4'd0) begin
              result_q <= result_d;
              done_q   <= 1'b1;
              state_q  <= DONE;
            end else begin
              cnt_q <= cnt_q - 4'd1;
            end
          end
          DONE: begin
            // The divide instruction leaves execute this cycle, so a start here is not ours.
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign stall_o     = accept | (state_q == SETTLE);
  assign done_o      = done_q;
  assign result_o    = result_q;
  assign div_op1_o   = op1_q;
  assign div_op2_o   = op2_q;
  assign div_ctrl_o  = ctrl_q;
  assign state_dbg_o = state_q;

endmodule

// File: tb/tb_div_mc_ctrl.sv
// Directed bench for div_mc_ctrl with a behavioural single-cycle divider attached to its outputs.
module tb_div_mc_ctrl;

  localparam int W  = 32;
  localparam int SC = 4;

  logic          clk;
  logic          rst_n;
  logic          start_i;
  logic [2:0]    div_ctrl_i;
  logic [W-1:0]  op1_i;
  logic [W-1:0]  op2_i;
  logic          flush_i;
  logic [W-1:0]  div_op1_o;
  logic [W-1:0]  div_op2_o;
  logic [2:0]    div_ctrl_o;
  logic [W-1:0]  div_result_i;
  logic          stall_o;
  logic          done_o;
  logic [W-1:0]  result_o;
  logic [1:0]    state_dbg_o;

  int checks;
  int errors;

  div_mc_ctrl #(.DATA_WIDTH(W), .DIV_CTRL(3), .SETTLE_CYCLES(SC)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start_i),
    .div_ctrl_i   (div_ctrl_i),
    .op1_i        (op1_i),
    .op2_i        (op2_i),
    .flush_i      (flush_i),
    .div_op1_o    (div_op1_o),
    .div_op2_o    (div_op2_o),
    .div_ctrl_o   (div_ctrl_o),
    .div_result_i (div_result_i),
    .stall_o      (stall_o),
    .done_o       (done_o),
    .result_o     (result_o),
    .state_dbg_o  (state_dbg_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Divider model: divide-by-zero gives 0, signed overflow gives a marker value.
  logic signed [W-1:0] sa;
  logic signed [W-1:0] sb;
  always_comb begin
    sa = div_op1_o;
    sb = div_op2_o;
    div_result_i = '0;
    if (div_op2_o == '0) begin
      div_result_i = '0;
    end else if (!div_ctrl_o[0] && div_op1_o == 32'h8000_0000 && div_op2_o == 32'hFFFF_FFFF) begin
      div_result_i = 32'hDEAD_BEEF;
    end else begin
      case (div_ctrl_o)
        3'b100:  div_result_i = sa / sb;
        3'b101:  div_result_i = div_op1_o / div_op2_o;
        3'b110:  div_result_i = sa % sb;
        3'b111:  div_result_i = div_op1_o % div_op2_o;
        default: div_result_i = '0;
      endcase
    end
  end

  // Runs one divide from its start cycle through the done cycle; leaves the bench in the done cycle.
  task automatic drive_divide(input logic [2:0] ctrl, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [W-1:0] exp, input string name);
    @(negedge clk);
    start_i = 1'b1; div_ctrl_i = ctrl; op1_i = a; op2_i = b;
    #1;
    checks++;
    if (stall_o !== 1'b1) begin
      errors++; $display("FAIL %s cycle0 stall got %b want 1", name, stall_o);
    end
    for (int c = 1; c <= SC; c++) begin
      @(negedge clk);
      start_i = 1'b0; op1_i = ~a; op2_i = ~b;
      #1;
      checks++;
      if (stall_o !== 1'b1 || done_o !== 1'b0) begin
        errors++; $display("FAIL %s cycle%0d stall/done got %b/%b want 1/0", name, c, stall_o, done_o);
      end
      checks++;
      if (div_op1_o !== a || div_op2_o !== b || div_ctrl_o !== ctrl) begin
        errors++; $display("FAIL %s cycle%0d operands got %h/%h/%b want %h/%h/%b",
                           name, c, div_op1_o, div_op2_o, div_ctrl_o, a, b, ctrl);
      end
    end
    @(negedge clk);
    #1;
    checks++;
    if (done_o !== 1'b1 || stall_o !== 1'b0) begin
      errors++; $display("FAIL %s done cycle done/stall got %b/%b want 1/0", name, done_o, stall_o);
    end
    checks++;
    if (result_o !== exp) begin
      errors++; $display("FAIL %s result got %h want %h", name, result_o, exp);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start_i = 1'b0; div_ctrl_i = 3'b000; op1_i = '0; op2_i = '0; flush_i = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (stall_o !== 1'b0 || done_o !== 1'b0 || result_o !== '0 || div_op1_o !== '0 ||
        div_op2_o !== '0 || div_ctrl_o !== 3'b000 || state_dbg_o !== 2'd0) begin
      errors++; $display("FAIL reset_state got stall=%b done=%b res=%h op1=%h op2=%h ctrl=%b st=%0d want all 0",
                         stall_o, done_o, result_o, div_op1_o, div_op2_o, div_ctrl_o, state_dbg_o);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_divu();
    drive_divide(3'b101, 32'd100, 32'd7, 32'd14, "divu_100_7");
    @(negedge clk);
    #1;
    checks++;
    if (done_o !== 1'b0 || result_o !== 32'd14) begin
      errors++; $display("FAIL divu_after done/result got %b/%h want 0/0000000e", done_o, result_o);
    end
  endtask

  task automatic test_rem_and_start_in_done();
    drive_divide(3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, "rem_m7_2");
    // still in the done cycle: present another divide, which must be ignored
    start_i = 1'b1; div_ctrl_i = 3'b101; op1_i = 32'd50; op2_i = 32'd5;
    @(negedge clk);
    start_i = 1'b0;
    #1;
    checks++;
    if (stall_o !== 1'b0 || state_dbg_o !== 2'd0 || div_op1_o !== 32'hFFFF_FFF9) begin
      errors++; $display("FAIL start_in_done stall=%b state=%0d op1=%h want 0/0/fffffff9",
                         stall_o, state_dbg_o, div_op1_o);
    end
    repeat (SC + 1) @(negedge clk);
    checks++;
    if (done_o !== 1'b0 || result_o !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL start_in_done_late done/result got %b/%h want 0/ffffffff", done_o, result_o);
    end
  endtask

  task automatic test_div_by_zero();
`ifdef DIV_RISCV_FIXUP_EN
    drive_divide(3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, "div_5_0");
    drive_divide(3'b111, 32'd9, 32'd0, 32'd9, "remu_9_0");
`else
    drive_divide(3'b100, 32'd5, 32'd0, 32'd0, "div_5_0");
    drive_divide(3'b111, 32'd9, 32'd0, 32'd0, "remu_9_0");
`endif
  endtask

  task automatic test_overflow();
`ifdef DIV_RISCV_FIXUP_EN
    drive_divide(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf");
    drive_divide(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, "rem_ovf");
`else
    drive_divide(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'hDEAD_BEEF, "div_ovf");
    drive_divide(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'hDEAD_BEEF, "rem_ovf");
`endif
    // unsigned divide of the same operands is an ordinary divide
    drive_divide(3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, "divu_big");
  endtask

  task automatic test_back_to_back();
    drive_divide(3'b101, 32'd1000, 32'd10, 32'd100, "b2b_first");
    drive_divide(3'b111, 32'd1000, 32'd7, 32'd6, "b2b_second");
  endtask

  task automatic test_flush();
    logic [W-1:0] prev;
    prev = result_o;
    @(negedge clk);
    start_i = 1'b1; div_ctrl_i = 3'b101; op1_i = 32'd77; op2_i = 32'd7;
    @(negedge clk);
    start_i = 1'b0;
    @(negedge clk);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    #1;
    checks++;
    if (stall_o !== 1'b0 || state_dbg_o !== 2'd0 || done_o !== 1'b0) begin
      errors++; $display("FAIL flush_idle stall/state/done got %b/%0d/%b want 0/0/0", stall_o, state_dbg_o, done_o);
    end
    for (int c = 0; c < SC + 2; c++) begin
      @(negedge clk);
      checks++;
      if (done_o !== 1'b0 || result_o !== prev) begin
        errors++; $display("FAIL flush_nodone done/result got %b/%h want 0/%h", done_o, result_o, prev);
      end
    end
    start_i = 1'b1; flush_i = 1'b1; div_ctrl_i = 3'b100; op1_i = 32'd40; op2_i = 32'd8;
    #1;
    checks++;
    if (stall_o !== 1'b0) begin
      errors++; $display("FAIL flush_start stall got %b want 0", stall_o);
    end
    @(negedge clk);
    start_i = 1'b0; flush_i = 1'b0;
    #1;
    checks++;
    if (stall_o !== 1'b0 || div_op1_o !== 32'd77 || state_dbg_o !== 2'd0) begin
      errors++; $display("FAIL flush_start_after stall/op1/state got %b/%h/%0d want 0/0000004d/0",
                         stall_o, div_op1_o, state_dbg_o);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    start_i = 1'b1; div_ctrl_i = 3'b101; op1_i = 32'd63; op2_i = 32'd9;
    @(negedge clk);
    start_i = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (stall_o !== 1'b0 || done_o !== 1'b0 || result_o !== '0 || div_op1_o !== '0 || state_dbg_o !== 2'd0) begin
      errors++; $display("FAIL async_reset stall/done/res/op1/state got %b/%b/%h/%h/%0d want 0",
                         stall_o, done_o, result_o, div_op1_o, state_dbg_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_i = 1'b1; div_ctrl_i = 3'b000; op1_i = 32'd3; op2_i = 32'd4;
    #1;
    checks++;
    if (stall_o !== 1'b0) begin
      errors++; $display("FAIL add_start stall got %b want 0", stall_o);
    end
    @(negedge clk);
    start_i = 1'b0;
    for (int c = 0; c < SC + 2; c++) begin
      @(negedge clk);
      checks++;
      if (stall_o !== 1'b0 || done_o !== 1'b0) begin
        errors++; $display("FAIL add_nodiv stall/done got %b/%b want 0/0", stall_o, done_o);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_divu();
    test_rem_and_start_in_done();
    test_div_by_zero();
    test_overflow();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
